// File: rtl/crc_pkt_sched.sv
// Packet scheduler ahead of the CRC stage: fixed-priority arbitration of handshake,
// token and data requesters, LSB-first serialization, then endb wait with timeout and gap.
module crc_pkt_sched #(
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tok_req,
  input  logic [7:0]  tok_pid,
  input  logic [6:0]  tok_addr,
  input  logic [3:0]  tok_endp,
  output logic        tok_gnt,
  input  logic        dat_req,
  input  logic [7:0]  dat_pid,
  input  logic [63:0] dat_payload,
  output logic        dat_gnt,
  input  logic        hs_req,
  input  logic [7:0]  hs_pid,
  output logic        hs_gnt,
  output logic [1:0]  pkt_out,
  output logic        s_out,
  output logic        endr,
  input  logic        endb_in,
  output logic        busy,
  output logic        timeout_err
);

  localparam int unsigned SR_W   = 72;
  localparam int unsigned LEN_W  = 7;
  localparam int unsigned GAP_W  = 4;
  localparam int unsigned TMO_W  = 8;
  localparam int unsigned CODE_W = 2;

  localparam logic [CODE_W-1:0] CODE_TOK = 2'b01;
  localparam logic [CODE_W-1:0] CODE_DAT = 2'b11;
  localparam logic [CODE_W-1:0] CODE_HS  = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    TYPE,
    SHIFT,
    ENDR,
    WAITB,
    GAP
  } state_t;

  state_t              state, state_d;
  logic [SR_W-1:0]     sreg, sreg_d;
  logic [LEN_W-1:0]    bit_cnt, bit_cnt_d;
  logic [GAP_W-1:0]    gap_cnt, gap_cnt_d;
  logic [TMO_W-1:0]    tmo_cnt, tmo_cnt_d;
  logic [TMO_W-1:0]    tmo_inc;
  logic [CODE_W-1:0]   ptype, ptype_d;
  logic                tok_gnt_d, dat_gnt_d, hs_gnt_d;
  logic [CODE_W-1:0]   pkt_out_d;
  logic                s_out_d, endr_d, busy_d, timeout_err_d;
  logic                wait_done;

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state       <= IDLE;
      sreg        <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      tmo_cnt     <= '0;
      ptype       <= '0;
      tok_gnt     <= 1'b0;
      dat_gnt     <= 1'b0;
      hs_gnt      <= 1'b0;
      pkt_out     <= '0;
      s_out       <= 1'b0;
      endr        <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      sreg        <= sreg_d;
      bit_cnt     <= bit_cnt_d;
      gap_cnt     <= gap_cnt_d;
      tmo_cnt     <= tmo_cnt_d;
      ptype       <= ptype_d;
      tok_gnt     <= tok_gnt_d;
      dat_gnt     <= dat_gnt_d;
      hs_gnt      <= hs_gnt_d;
      pkt_out     <= pkt_out_d;
      s_out       <= s_out_d;
      endr        <= endr_d;
      busy        <= busy_d;
      timeout_err <= timeout_err_d;
    end
  end

  // Next state, datapath updates and next-cycle output values
  always_comb begin
    state_d       = state;
    sreg_d        = sreg;
    bit_cnt_d     = bit_cnt;
    gap_cnt_d     = gap_cnt;
    tmo_cnt_d     = tmo_cnt;
    ptype_d       = ptype;
    tok_gnt_d     = 1'b0;
    dat_gnt_d     = 1'b0;
    hs_gnt_d      = 1'b0;
    pkt_out_d     = '0;
    s_out_d       = 1'b0;
    endr_d        = 1'b0;
    timeout_err_d = 1'b0;
    wait_done     = 1'b0;
    tmo_inc       = tmo_cnt + TMO_W'(1);

    case (state)
      IDLE: begin
        if (hs_req) begin
          hs_gnt_d  = 1'b1;
          sreg_d    = SR_W'(hs_pid);
          bit_cnt_d = LEN_W'(8);
          ptype_d   = CODE_HS;
          state_d   = TYPE;
        end else if (tok_req) begin
          tok_gnt_d = 1'b1;
          sreg_d    = SR_W'({tok_endp, tok_addr, tok_pid});
          bit_cnt_d = LEN_W'(19);
          ptype_d   = CODE_TOK;
          state_d   = TYPE;
        end else if (dat_req) begin
          dat_gnt_d = 1'b1;
          sreg_d    = {dat_payload, dat_pid};
          bit_cnt_d = LEN_W'(72);
          ptype_d   = CODE_DAT;
          state_d   = TYPE;
        end
      end
      TYPE: begin
        pkt_out_d = ptype;
        state_d   = SHIFT;
      end
      SHIFT: begin
        s_out_d   = sreg[0];
        sreg_d    = {1'b0, sreg[SR_W-1:1]};
        bit_cnt_d = bit_cnt - LEN_W'(1);
        if (bit_cnt == LEN_W'(1)) state_d = ENDR;
      end
      ENDR: begin
        endr_d    = 1'b1;
        tmo_cnt_d = '0;
        state_d   = WAITB;
      end
      WAITB: begin
        // endb on the cycle the count reaches the limit still counts as success
        if (endb_in) begin
          wait_done = 1'b1;
        end else begin
          if (tmo_cnt != '1) tmo_cnt_d = tmo_inc;
          if (tmo_inc == TMO_W'(TIMEOUT)) begin
            timeout_err_d = 1'b1;
            wait_done     = 1'b1;
          end
        end
        if (wait_done) begin
          gap_cnt_d = '0;
          state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) state_d = IDLE;
        else gap_cnt_d = gap_cnt + GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_crc_pkt_sched.sv
// Randomized bench for crc_pkt_sched: per-cycle trace capture compared against a
// bit-queue packet model and timing arithmetic derived from the packet rules.
module tb_crc_pkt_sched;

  localparam int unsigned GAP  = 4;
  localparam int unsigned TMO  = 200;
  localparam int          MAXC = 512;
  localparam int          HS_B = 2;
  localparam int          TK_B = 1;
  localparam int          DT_B = 0;

  logic        clk;
  logic        rst_n;
  logic        tok_req, dat_req, hs_req;
  logic [7:0]  tok_pid, dat_pid, hs_pid;
  logic [6:0]  tok_addr;
  logic [3:0]  tok_endp;
  logic [63:0] dat_payload;
  logic        tok_gnt, dat_gnt, hs_gnt;
  logic [1:0]  pkt_out;
  logic        s_out, endr, endb_in, busy, timeout_err;

  int checks = 0;
  int errors = 0;

  logic [2:0] tr_gnt  [MAXC];
  logic [1:0] tr_pkt  [MAXC];
  logic       tr_s    [MAXC];
  logic       tr_endr [MAXC];
  logic       tr_tmo  [MAXC];
  logic       tr_busy [MAXC];
  int         tr_len = 0;

  crc_pkt_sched #(.GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .tok_req(tok_req), .tok_pid(tok_pid), .tok_addr(tok_addr), .tok_endp(tok_endp), .tok_gnt(tok_gnt),
    .dat_req(dat_req), .dat_pid(dat_pid), .dat_payload(dat_payload), .dat_gnt(dat_gnt),
    .hs_req(hs_req), .hs_pid(hs_pid), .hs_gnt(hs_gnt),
    .pkt_out(pkt_out), .s_out(s_out), .endr(endr), .endb_in(endb_in),
    .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference packet: field bits appended in transmit order
  function automatic logic [71:0] exp_stream(input int kind, input logic [7:0] pid,
                                             input logic [6:0] addr, input logic [3:0] endp,
                                             input logic [63:0] pl);
    bit q[$];
    logic [71:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) q.push_back(pid[i]);
    if (kind == 1) begin
      for (int i = 0; i < 7; i++) q.push_back(addr[i]);
      for (int i = 0; i < 4; i++) q.push_back(endp[i]);
    end else if (kind == 2) begin
      for (int i = 0; i < 64; i++) q.push_back(pl[i]);
    end
    foreach (q[i]) v[i] = q[i];
    return v;
  endfunction

  function automatic logic [71:0] got_stream(input int start, input int len);
    logic [71:0] v;
    v = '0;
    for (int i = 0; i < len; i++)
      if (start + i >= 0 && start + i < tr_len) v[i] = tr_s[start + i];
    return v;
  endfunction

  function automatic int find_gnt(input int sel, input int from);
    for (int c = (from < 0) ? 0 : from; c < tr_len; c++) if (tr_gnt[c][sel]) return c;
    return -1;
  endfunction

  function automatic int find_any_gnt(input int from);
    for (int c = (from < 0) ? 0 : from; c < tr_len; c++) if (tr_gnt[c] != 3'b000) return c;
    return -1;
  endfunction

  function automatic int find_endr(input int from);
    for (int c = (from < 0) ? 0 : from; c < tr_len; c++) if (tr_endr[c]) return c;
    return -1;
  endfunction

  function automatic int find_tmo(input int from);
    for (int c = (from < 0) ? 0 : from; c < tr_len; c++) if (tr_tmo[c]) return c;
    return -1;
  endfunction

  function automatic int count_endr(input int a, input int b);
    int n = 0;
    for (int c = (a < 0) ? 0 : a; c < b && c < tr_len; c++) if (tr_endr[c]) n++;
    return n;
  endfunction

  function automatic int count_tmo(input int a, input int b);
    int n = 0;
    for (int c = (a < 0) ? 0 : a; c < b && c < tr_len; c++) if (tr_tmo[c]) n++;
    return n;
  endfunction

  // Capture n cycles; requesters drop on grant, endb follows each endr by dly cycles
  task automatic record(input int n, input int dly, input int stray_at, input int tok_at);
    int due = -1;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      tr_gnt[c]  = {hs_gnt, tok_gnt, dat_gnt};
      tr_pkt[c]  = pkt_out;
      tr_s[c]    = s_out;
      tr_endr[c] = endr;
      tr_tmo[c]  = timeout_err;
      tr_busy[c] = busy;
      if (hs_gnt)  hs_req  = 1'b0;
      if (tok_gnt) tok_req = 1'b0;
      if (dat_gnt) dat_req = 1'b0;
      if (endr && dly >= 0) due = c + dly;
      endb_in = (c == due) || (c == stray_at);
      if (c == tok_at) tok_req = 1'b1;
    end
    tr_len  = n;
    endb_in = 1'b0;
  endtask

  task automatic clear_inputs();
    tok_req = 0; dat_req = 0; hs_req = 0; endb_in = 0;
    tok_pid = 0; tok_addr = 0; tok_endp = 0; dat_pid = 0; dat_payload = 0; hs_pid = 0;
  endtask

  task automatic rand_fields();
    tok_pid     = 8'($urandom);
    tok_addr    = 7'($urandom);
    tok_endp    = 4'($urandom);
    dat_pid     = 8'($urandom);
    dat_payload = {32'($urandom), 32'($urandom)};
    hs_pid      = 8'($urandom);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 700 && !ok; i++) begin
      @(negedge clk);
      if (busy === 1'b0) ok = 1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_idle busy got %b exp 0", busy);
    end
  endtask

  task automatic test_reset();
    rand_fields();
    tok_req = 1; dat_req = 1; hs_req = 1; endb_in = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({hs_gnt, tok_gnt, dat_gnt} !== 3'b000) begin
      errors++; $display("FAIL reset_gnt got %b exp 000", {hs_gnt, tok_gnt, dat_gnt});
    end
    checks++;
    if ({pkt_out, s_out, endr, busy, timeout_err} !== 6'b0) begin
      errors++; $display("FAIL reset_outs got %b exp 000000", {pkt_out, s_out, endr, busy, timeout_err});
    end
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, pkt_out, hs_gnt, tok_gnt, dat_gnt} !== 6'b0) begin
      errors++; $display("FAIL idle_no_req got %b exp 000000", {busy, pkt_out, hs_gnt, tok_gnt, dat_gnt});
    end
  endtask

  task automatic test_token();
    int g, r;
    logic [71:0] e;
    tok_pid = 8'hE1; tok_addr = 7'h05; tok_endp = 4'h2; tok_req = 1;
    record(60, 3, -1, -1);
    e = exp_stream(1, tok_pid, tok_addr, tok_endp, 64'h0);
    g = find_gnt(TK_B, 0);
    checks++;
    if (g !== 0) begin errors++; $display("FAIL tok_gnt_cycle got %0d exp 0", g); end
    if (g < 0) g = 0;
    checks++;
    if (find_any_gnt(g + 1) !== -1) begin
      errors++; $display("FAIL tok_single_gnt got %0d exp -1", find_any_gnt(g + 1));
    end
    checks++;
    if ({tr_pkt[g], tr_pkt[g+1], tr_pkt[g+2]} !== 6'b00_01_00) begin
      errors++; $display("FAIL tok_pkt_out got %b exp 000100", {tr_pkt[g], tr_pkt[g+1], tr_pkt[g+2]});
    end
    checks++;
    if (got_stream(g + 2, 19) !== e) begin
      errors++; $display("FAIL tok_stream got %h exp %h", got_stream(g + 2, 19), e);
    end
    r = find_endr(0);
    checks++;
    if (r !== g + 21 || count_endr(0, tr_len) !== 1) begin
      errors++; $display("FAIL tok_endr got %0d (n=%0d) exp %0d (n=1)", r, count_endr(0, tr_len), g + 21);
    end
    if (r < 0) r = 0;
    checks++;
    if ({tr_busy[r+7], tr_busy[r+8], 1'(count_tmo(0, tr_len))} !== 3'b100) begin
      errors++; $display("FAIL tok_busy_drop got %b exp 100", {tr_busy[r+7], tr_busy[r+8], 1'(count_tmo(0, tr_len))});
    end
  endtask

  task automatic test_data();
    int g, r, d;
    logic [71:0] e, s;
    for (int it = 0; it < 4; it++) begin
      rand_fields();
      if (it == 0) begin dat_pid = 8'hC3; dat_payload = 64'h1; end
      d = int'($urandom_range(0, 6));
      dat_req = 1;
      record(110, d, -1, -1);
      e = exp_stream(2, dat_pid, 7'h0, 4'h0, dat_payload);
      g = find_gnt(DT_B, 0);
      checks++;
      if (g !== 0 || tr_pkt[1] !== 2'b11) begin
        errors++; $display("FAIL dat_gnt_pkt[%0d] got %0d/%b exp 0/11", it, g, tr_pkt[1]);
      end
      if (g < 0) g = 0;
      s = got_stream(g + 2, 72);
      checks++;
      if (s !== e) begin errors++; $display("FAIL dat_stream[%0d] got %h exp %h", it, s, e); end
      if (it == 0) begin
        checks++;
        if ({s[71:8]} !== 64'h1) begin
          errors++; $display("FAIL dat_one_bit got %h exp 1", s[71:8]);
        end
      end
      r = find_endr(0);
      checks++;
      if (r !== g + 74) begin errors++; $display("FAIL dat_endr[%0d] got %0d exp %0d", it, r, g + 74); end
      if (r < 0) r = 0;
      checks++;
      if ({tr_busy[r+d+4], tr_busy[r+d+5]} !== 2'b10) begin
        errors++; $display("FAIL dat_busy[%0d] got %b exp 10", it, {tr_busy[r+d+4], tr_busy[r+d+5]});
      end
      wait_idle();
    end
  endtask

  task automatic test_priority();
    int lens[3];
    logic [1:0] codes[3];
    int d, g, g_exp, r;
    logic [71:0] e;
    lens  = '{8, 19, 72};
    codes = '{2'b10, 2'b01, 2'b11};
    rand_fields();
    d = int'($urandom_range(0, 5));
    hs_req = 1; tok_req = 1; dat_req = 1;
    record(300, d, -1, -1);
    g_exp = 0;
    g = -1;
    for (int k = 0; k < 3; k++) begin
      g = find_any_gnt(g + 1);
      checks++;
      if (g !== g_exp || (g >= 0 && tr_gnt[g] !== 3'(1 << (2 - k)))) begin
        errors++; $display("FAIL prio_gnt[%0d] got %0d/%b exp %0d/%b", k, g, (g >= 0) ? tr_gnt[g] : 3'b0, g_exp, 3'(1 << (2 - k)));
      end
      if (g < 0) g = g_exp;
      e = exp_stream(k, (k == 0) ? hs_pid : (k == 1) ? tok_pid : dat_pid, tok_addr, tok_endp, dat_payload);
      checks++;
      if (tr_pkt[g+1] !== codes[k] || got_stream(g + 2, lens[k]) !== e) begin
        errors++; $display("FAIL prio_pkt[%0d] got %b/%h exp %b/%h", k, tr_pkt[g+1], got_stream(g + 2, lens[k]), codes[k], e);
      end
      r = find_endr(g);
      checks++;
      if (r !== g + lens[k] + 2) begin
        errors++; $display("FAIL prio_endr[%0d] got %0d exp %0d", k, r, g + lens[k] + 2);
      end
      g_exp = g + lens[k] + d + int'(GAP) + 4;
    end
    checks++;
    if (find_any_gnt(g + 1) !== -1 || tr_busy[tr_len-1] !== 1'b0) begin
      errors++; $display("FAIL prio_tail got %0d/%b exp -1/0", find_any_gnt(g + 1), tr_busy[tr_len-1]);
    end
  endtask

  task automatic test_timeout();
    int r, t;
    rand_fields();
    tok_req = 1; dat_req = 1;
    record(260, -1, -1, -1);
    r = find_endr(0);
    t = find_tmo(0);
    checks++;
    if (r !== 21 || t !== r + int'(TMO)) begin
      errors++; $display("FAIL tmo_cycle got endr %0d tmo %0d exp endr 21 tmo %0d", r, t, 21 + int'(TMO));
    end
    if (t < 0) t = 21 + int'(TMO);
    checks++;
    if ({tr_tmo[t+1], tr_busy[t+3], tr_busy[t+4]} !== 3'b010) begin
      errors++; $display("FAIL tmo_pulse_gap got %b exp 010", {tr_tmo[t+1], tr_busy[t+3], tr_busy[t+4]});
    end
    checks++;
    if (find_gnt(DT_B, 0) !== t + 5 || tr_pkt[t+6] !== 2'b11) begin
      errors++; $display("FAIL tmo_next_gnt got %0d/%b exp %0d/11", find_gnt(DT_B, 0), tr_pkt[t+6], t + 5);
    end
  endtask

  task automatic test_timeout_edge();
    int r;
    rand_fields();
    tok_req = 1;
    record(240, int'(TMO) - 1, -1, -1);
    r = find_endr(0);
    if (r < 0) r = 21;
    checks++;
    if (count_tmo(0, tr_len) !== 0 || {tr_busy[r+203], tr_busy[r+204]} !== 2'b10) begin
      errors++; $display("FAIL tmo_edge got n=%0d busy %b exp n=0 busy 10", count_tmo(0, tr_len), {tr_busy[r+203], tr_busy[r+204]});
    end
  endtask

  task automatic test_reset_mid();
    bit got = 0;
    rand_fields();
    dat_req = 1;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (dat_gnt === 1'b1) begin got = 1; dat_req = 0; end
    end
    checks++;
    if (!got) begin errors++; $display("FAIL rmid_dat_gnt got 0 exp 1"); end
    repeat (12) @(negedge clk);
    checks++;
    if ({s_out, busy, pkt_out} !== {dat_payload[2], 1'b1, 2'b00}) begin
      errors++; $display("FAIL rmid_bit10 got %b exp %b", {s_out, busy, pkt_out}, {dat_payload[2], 1'b1, 2'b00});
    end
    rst_n = 1'b1;
    tok_req = 1;
    #1;
    checks++;
    if ({hs_gnt, tok_gnt, dat_gnt, pkt_out, s_out, endr, busy, timeout_err} !== 9'b0) begin
      errors++; $display("FAIL rmid_async got %b exp 0", {hs_gnt, tok_gnt, dat_gnt, pkt_out, s_out, endr, busy, timeout_err});
    end
    @(negedge clk);
    checks++;
    if ({tok_gnt, busy, endr, timeout_err} !== 4'b0) begin
      errors++; $display("FAIL rmid_held got %b exp 0000", {tok_gnt, busy, endr, timeout_err});
    end
    rst_n = 1'b0;
    record(40, 0, -1, -1);
    checks++;
    if (find_gnt(TK_B, 0) !== 0 || find_gnt(DT_B, 0) !== -1 || tr_pkt[1] !== 2'b01 || find_endr(0) !== 21) begin
      errors++; $display("FAIL rmid_restart got tok %0d dat %0d pkt %b endr %0d exp 0 -1 01 21",
                         find_gnt(TK_B, 0), find_gnt(DT_B, 0), tr_pkt[1], find_endr(0));
    end
  endtask

  task automatic test_late_req();
    logic [71:0] e;
    rand_fields();
    dat_req = 1;
    record(140, 5, 30, 75);
    e = exp_stream(1, tok_pid, tok_addr, tok_endp, 64'h0);
    checks++;
    if (find_endr(0) !== 74 || {tr_busy[83], tr_busy[84]} !== 2'b10) begin
      errors++; $display("FAIL late_stray_endb got endr %0d busy %b exp 74 10", find_endr(0), {tr_busy[83], tr_busy[84]});
    end
    checks++;
    if (find_gnt(TK_B, 0) !== 85) begin
      errors++; $display("FAIL late_tok_gnt got %0d exp 85", find_gnt(TK_B, 0));
    end
    checks++;
    if (got_stream(87, 19) !== e || count_tmo(0, tr_len) !== 0) begin
      errors++; $display("FAIL late_tok_stream got %h exp %h", got_stream(87, 19), e);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    clear_inputs();
    test_reset();
    test_token();
    wait_idle();
    test_data();
    test_priority();
    wait_idle();
    test_timeout();
    wait_idle();
    test_timeout_edge();
    wait_idle();
    test_reset_mid();
    wait_idle();
    test_late_req();
    wait_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc_pkt_sched.md
Name: crc_pkt_sched

Overview:
- Packet scheduler in front of the CRC stage: arbitrates token, data and handshake requesters and serializes the winning packet's bits.
- For each packet it issues the packet-type code, the serial bit stream and the end-of-region strobe to the CRC block, then waits for the bit stuffer's end-of-packet before admitting the next packet.
- Enforces an inter-packet gap and a completion timeout.

Parameters:
- GAP_CYCLES, 4: idle cycles inserted after each packet completes; legal range 0..15.
- TIMEOUT, 200: cycles to wait for endb_in before aborting; 8-bit counter; legal range 1..255.

Ports:
- clk  input  1  system clock; one clock.
- rst_n  input  1  reset; asynchronous and active-high (rst_n=1 resets).
- tok_req  input  1  token packet request; level, held until tok_gnt.
- tok_pid  input  8  token PID.
- tok_addr  input  7  device address.
- tok_endp  input  4  endpoint number.
- tok_gnt  output  1  one-cycle grant; fields latched on this cycle.
- dat_req  input  1  data packet request.
- dat_pid  input  8  data PID.
- dat_payload  input  64  data payload.
- dat_gnt  output  1  one-cycle grant.
- hs_req  input  1  handshake request.
- hs_pid  input  8  handshake PID.
- hs_gnt  output  1  one-cycle grant.
- pkt_out  output  2  to CRC pkt_in: 00 idle, 01 token, 11 data, 10 handshake.
- s_out  output  1  to CRC s_in: serial packet bit.
- endr  output  1  to CRC endr: end of serialized region.
- endb_in  input  1  from bit stuffer: packet fully drained.
- busy  output  1  high in every state except IDLE.
- timeout_err  output  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset: state IDLE. All outputs 0; shift register, bit counter, gap counter and timeout counter cleared. Reset mid-packet aborts immediately with no grant, endr or timeout_err; the next packet starts from IDLE.
- States: IDLE, TYPE, SHIFT, ENDR, WAITB, GAP.
- IDLE:
  - Arbitration is fixed priority: hs_req > tok_req > dat_req.
  - The winner's gnt pulses for one cycle; fields latch into a 72-bit shift register.
  - Length latches into a 7-bit counter: hs 8, token 19, data 72.
  - Next state TYPE. No request means stay in IDLE.
- Requests arriving in any state other than IDLE are not granted; they are held until the next IDLE. Deasserting a request before its grant has no effect.
- TYPE (1 cycle): pkt_out = type code; s_out = 0. Next state SHIFT.
- SHIFT:
  - One bit per cycle on s_out, LSB first.
  - Bit order: PID[0..7], then addr[0..6] and endp[0..3] (token), or payload[0..63] (data).
  - First bit appears the cycle after TYPE; exactly length cycles.
  - pkt_out = 00 in this state. After the last bit, go to ENDR.
- ENDR (1 cycle): endr = 1, s_out = 0, for all types. Next state WAITB; timeout counter cleared.
- WAITB:
  - endb_in = 1 goes to GAP.
  - Otherwise the counter increments; on reaching TIMEOUT, timeout_err pulses and the state goes to GAP.
  - endb_in on the same cycle the count reaches TIMEOUT is treated as success: no timeout_err.
  - endb_in outside WAITB is ignored.
- GAP: GAP_CYCLES idle cycles, then IDLE. With GAP_CYCLES = 0, WAITB goes directly to IDLE.
- Latency:
  - Grant to first data bit is 2 cycles.
  - Back-to-back packet grants are spaced by at least 1+1+len+1+(WAITB cycles)+GAP_CYCLES cycles.
- Counter widths: bit counter 7 bits, no wrap (maximum 72). Timeout counter 8 bits, saturating. Gap counter 4 bits.

Test Plan:
- Token request: tok_pid=8'hE1, tok_addr=7'h05, tok_endp=4'h2.
  - Expect tok_gnt 1 cycle, then pkt_out=01 for 1 cycle.
  - s_out sequence 1,0,0,0,0,1,1,1 / 1,0,1,0,0,0,0 / 0,1,0,0 (19 bits), then endr for 1 cycle.
  - endb_in 3 cycles later; busy drops 4 cycles after endb_in.
- Data request: dat_pid=8'hC3, dat_payload=64'h1.
  - pkt_out=11; 72 bits; bit 8 of the stream = 1 and bits 9..71 = 0; endr follows.
- Simultaneous hs_req, tok_req and dat_req in IDLE.
  - Order of grants is hs, then tok, then dat, each after the previous packet's endb_in plus the 4-cycle gap.
  - hs packet is 8 bits with pkt_out=10.
- endb_in never asserted after a token.
  - timeout_err pulses exactly 200 cycles after ENDR; the next request is granted after the gap.
- Reset (rst_n=1) during SHIFT at bit 10 of a data packet.
  - All outputs go to 0 immediately; after release, a pending tok_req is granted on the first IDLE cycle.
- tok_req asserted during WAITB of a data packet.
  - No tok_gnt until IDLE; endb_in asserted outside WAITB is ignored.
